// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: the per-instruction
// metadata record carried down the pipeline, the predictor counter
// encodings, the PC increment, and a saturating-increment helper.
package bru_pkg;

  localparam int BRU_XLEN = 32;

  localparam logic [BRU_XLEN-1:0] PC_INC = 32'd4;

  // Two-bit direction counter encodings used by the predictor.
  localparam logic [1:0] CNT_ST  = 2'b11;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_SNT = 2'b00;

  typedef struct packed {
    logic                valid;
    logic [BRU_XLEN-1:0] pc;
    logic                hit;
    logic                taken;
    logic [BRU_XLEN-1:0] pred_addr;
  } bru_meta_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bru_meta_stage.sv
// One pipeline register of prediction metadata. Clear wins over hold so a
// flush always empties the stage, even while the pipeline is stalled.
module bru_meta_stage
  import bru_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      clear,
  input  bru_meta_t d,
  output bru_meta_t q
);

  // Register the metadata: reset/clear empty it, hold freezes it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries fetch-time prediction metadata through IF/ID
// and ID/EX, compares it with the real outcome in EX, and produces registered
// predictor-update, redirect and flush pulses one cycle after evaluation.
// Optional statistics counters are built only when BRU_STATS_EN is defined.
// XLEN must match bru_pkg::BRU_XLEN, since the metadata record is sized there.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN = BRU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] pc_if,
  input  logic            pred_hit_if,
  input  logic            pred_taken_if,
  input  logic [XLEN-1:0] pred_addr_if,
  input  logic            stall,
  input  logic            ex_is_branch,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] ADDR_EX,
  output logic [XLEN-1:0] Pred_EX,
  output logic            btb_enable,
  output logic            state_write,
  output logic            state_change,
  output logic            branch,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  bru_meta_t if_meta;
  bru_meta_t ifid_q;
  bru_meta_t idex_q;

  logic            eval;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pred_next;
  logic [XLEN-1:0] act_next;
  logic            mispredict;
  logic            redirect_q;

  assign if_meta = '{valid:     if_valid,
                     pc:        pc_if,
                     hit:       pred_hit_if,
                     taken:     pred_taken_if,
                     pred_addr: pred_addr_if};

  bru_meta_stage u_ifid (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .clear (redirect_q),
    .d     (if_meta),
    .q     (ifid_q)
  );

  bru_meta_stage u_idex (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .clear (redirect_q),
    .d     (ifid_q),
    .q     (idex_q)
  );

  // Evaluate the ID/EX instruction once: not while stalled or being flushed.
  always_comb begin
    eval       = idex_q.valid & ~stall & ~redirect_q;
    pc_plus4   = idex_q.pc + PC_INC;
    pred_next  = (idex_q.hit & idex_q.taken) ? idex_q.pred_addr : pc_plus4;
    act_next   = (ex_is_branch & ex_taken) ? ex_target : pc_plus4;
    mispredict = (act_next != pred_next);
  end

  // Register the update/redirect pulses; addresses hold between evaluations.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch       <= 1'b0;
      state_change <= 1'b0;
      state_write  <= 1'b0;
      btb_enable   <= 1'b0;
      redirect_q   <= 1'b0;
      ADDR_EX      <= '0;
      Pred_EX      <= '0;
      redirect_pc  <= '0;
    end else begin
      branch       <= eval & ex_is_branch;
      state_change <= eval & ex_taken;
      state_write  <= eval & ex_is_branch & idex_q.hit;
      btb_enable   <= eval & ex_is_branch & ~idex_q.hit & ex_taken;
      redirect_q   <= eval & mispredict;
      if (eval) begin
        ADDR_EX     <= idex_q.pc;
        Pred_EX     <= ex_target;
        redirect_pc <= act_next;
      end
    end
  end

  assign redirect = redirect_q;
  assign flush    = redirect_q;

`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  // Saturating counts of evaluated branches and of mispredicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (eval) begin
      if (ex_is_branch) branch_cnt_q     <= sat_inc(branch_cnt_q);
      if (mispredict)   mispredict_cnt_q <= sat_inc(mispredict_cnt_q);
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispredict_cnt_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule
